// File: rtl/atm_arb_pkg.sv
// atm_arb_pkg: shared state/response encodings for the account arbiter.
// Imported by the round-robin picker and the arbiter top.
package atm_arb_pkg;

  localparam int RESP_ID_W = 3;
  localparam int ST_W      = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OK     = 2'd0,
    FONDOS = 2'd1,
    OVF    = 2'd2,
    TMO    = 2'd3
  } resp_t;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/atm_rr_picker.sv
// atm_rr_picker: combinational round-robin pick.
// First set req bit at or after ptr, wrapping modulo N.
module atm_rr_picker
  import atm_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [SEL_W-1:0] k;
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    k    = '0;
    for (int i = 0; i < N; i++) begin
      k = SEL_W'((int'(ptr) + i) % N);
      if (!any && req[k]) begin
        any     = 1'b1;
        pick[k] = 1'b1;
        idx     = k;
      end
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter: round-robin access of N_TERM ATM terminals
// to one shared account balance register.
module atm_account_arbiter
  import atm_arb_pkg::*;
#(
  parameter int               N_TERM       = 4,
  parameter int               MONTO_W      = 32,
  parameter int               BAL_W        = 64,
  parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(4500),
  parameter int               TIMEOUT_CYC  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_TERM-1:0]         req,
  input  logic [N_TERM-1:0]         tipo_trans,
  input  logic [N_TERM-1:0]         monto_stb,
  input  logic [N_TERM*MONTO_W-1:0] monto,
  output logic [N_TERM-1:0]         grant,
  output logic [RESP_ID_W-1:0]      resp_id,
  output logic                      balance_actualizado,
  output logic                      entregar_dinero,
  output logic                      fondos_insuficientes,
  output logic                      desbordamiento,
  output logic                      timeout,
  output logic [BAL_W-1:0]          balance,
  output logic                      busy
);

  localparam int SEL_W = $clog2(N_TERM);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t            state;
  state_t            state_nx;
  resp_t             code;
  resp_t             code_nx;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  sel_inc;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  pick_idx;
  logic [N_TERM-1:0] pick;
  logic              pick_any;
  logic [TMR_W-1:0]  timer;
  logic [MONTO_W-1:0] monto_q;
  logic              tipo_q;
  logic [BAL_W-1:0]  bal_nx;
  logic [BAL_W:0]    sum;
  logic [BAL_W:0]    amt;
  logic              stb_sel;
  logic              req_sel;
  logic              tmo_hit;

  atm_rr_picker #(
    .N     (N_TERM),
    .SEL_W (SEL_W)
  ) u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign stb_sel = monto_stb[sel];
  assign req_sel = req[sel];
  assign tmo_hit = (timer == TMR_LAST);
  assign sel_inc = SEL_W'(wrap_inc(int'(sel), N_TERM));
  assign amt     = (BAL_W+1)'(monto_q);
  assign resp_id = RESP_ID_W'(sel);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Strobe beats abort, abort beats timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (pick_any) state_nx = GRANT;
      GRANT: begin
        if (stb_sel)       state_nx = EXEC;
        else if (!req_sel) state_nx = IDLE;
        else if (tmo_hit)  state_nx = RESP;
      end
      EXEC:  state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    code_nx = OK;
    bal_nx  = balance;
    sum     = '0;
    if (!tipo_q) begin
      sum = {1'b0, balance} + amt;
      if (sum[BAL_W]) code_nx = OVF;
      else            bal_nx  = sum[BAL_W-1:0];
    end else if (amt > {1'b0, balance}) begin
      code_nx = FONDOS;
    end else begin
      sum    = {1'b0, balance} - amt;
      bal_nx = sum[BAL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant   <= '0;
      sel     <= '0;
      rr_ptr  <= '0;
      timer   <= '0;
      monto_q <= '0;
      tipo_q  <= 1'b0;
      code    <= OK;
      balance <= INIT_BALANCE;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick;
            sel   <= pick_idx;
            timer <= '0;
          end
        end
        GRANT: begin
          if (stb_sel) begin
            monto_q <= monto[int'(sel)*MONTO_W +: MONTO_W];
            tipo_q  <= tipo_trans[sel];
          end else if (!req_sel) begin
            grant  <= '0;
            rr_ptr <= sel_inc;
          end else if (tmo_hit) begin
            code <= TMO;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        EXEC: begin
          code    <= code_nx;
          balance <= bal_nx;
        end
        RESP: begin
          grant  <= '0;
          rr_ptr <= sel_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    balance_actualizado  = 1'b0;
    entregar_dinero      = 1'b0;
    fondos_insuficientes = 1'b0;
    desbordamiento       = 1'b0;
    timeout              = 1'b0;
    if (state == RESP) begin
      unique case (code)
        OK: begin
          balance_actualizado = 1'b1;
          entregar_dinero     = tipo_q;
        end
        FONDOS: fondos_insuficientes = 1'b1;
        OVF:    desbordamiento       = 1'b1;
        TMO:    timeout              = 1'b1;
      endcase
    end
  end

endmodule
